// File: rtl/sketch_counter_updater_pkg.sv
// Shared types, constants and helpers for the sketch counter updater.
// Holds the OpenSketch flow-entry field positions, the default sketch index
// width, the controller state encoding and the saturating drop-counter step.
package sketch_counter_updater_pkg;

   // Flow-entry field positions and sketch geometry shared by the data path.
   localparam int unsigned OPENSKETCH_ENTRY_IP_SRC_POS   = 64;
   localparam int unsigned OPENSKETCH_SKETCH_INDEX_WIDTH = 10;

   localparam int unsigned DROP_COUNT_WIDTH = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } sketch_state_e;

   // Increment that sticks at all-ones.
   function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc_drop(
      input logic [DROP_COUNT_WIDTH-1:0] v
   );
      return (&v) ? v : v + DROP_COUNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/sketch_counter_ram.sv
// Simple dual-port counter table with a one-cycle synchronous read.
// A read and a write to the same address on the same edge returns the old
// contents (read-first); the updater forwards around this itself.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
// rd_data registered read data.
module sketch_counter_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Read port; sees pre-write contents on a same-edge collision.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/sketch_counter_updater.sv
// Count-min style single-row counter updater.
// Queues {key, pkt_size} from each valid flow entry, hashes the key to a table
// index and does a three-stage read-modify-write with saturating add. Also
// provides a software read port and a whole-table clear sweep.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flow_entry, pkt_size, flow_entry_vld   parsed packet input (pulse)
//   sw_rd_req, sw_rd_addr -> sw_rd_ack, sw_rd_data   software read
//   sw_clear_req -> clear_busy                     table clear
//   drop_count          entries lost to a full input queue (saturating)
module sketch_counter_updater
   import sketch_counter_updater_pkg::*;
#(
   parameter int unsigned          FLOW_ENTRY_SIZE = 240,
   parameter int unsigned          PKT_SIZE_WIDTH  = 12,
   parameter int unsigned          KEY_POS         = OPENSKETCH_ENTRY_IP_SRC_POS,
   parameter int unsigned          KEY_WIDTH       = 32,
   parameter int unsigned          INDEX_WIDTH     = OPENSKETCH_SKETCH_INDEX_WIDTH,
   parameter int unsigned          COUNTER_WIDTH   = 32,
   parameter int unsigned          COUNT_BYTES     = 0,
   parameter logic [KEY_WIDTH-1:0] HASH_SEED       = KEY_WIDTH'(32'h9E3779B9),
   parameter int unsigned          FIFO_DEPTH_BITS = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [FLOW_ENTRY_SIZE-1:0]  flow_entry,
   input  logic [PKT_SIZE_WIDTH-1:0]   pkt_size,
   input  logic                        flow_entry_vld,
   input  logic                        sw_rd_req,
   input  logic [INDEX_WIDTH-1:0]      sw_rd_addr,
   output logic                        sw_rd_ack,
   output logic [COUNTER_WIDTH-1:0]    sw_rd_data,
   input  logic                        sw_clear_req,
   output logic                        clear_busy,
   output logic [DROP_COUNT_WIDTH-1:0] drop_count
);
   localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int unsigned CNT_W      = FIFO_DEPTH_BITS + 1;
   localparam int unsigned FIFO_W     = KEY_WIDTH + PKT_SIZE_WIDTH;
   localparam int unsigned NUM_SLICES = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
   localparam int unsigned HASH_PAD_W = NUM_SLICES * INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_ADDR = '1;

   // Input queue
   logic [FIFO_W-1:0]          fifo_mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d;
   logic [FIFO_DEPTH_BITS-1:0] fifo_rd_ptr_q, fifo_rd_ptr_d;
   logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
   logic                       fifo_full_c, fifo_empty_c;
   logic                       push_c, pop_c;
   logic [FIFO_W-1:0]          push_data_c, head_c;
   logic [KEY_WIDTH-1:0]       head_key_c;
   logic [PKT_SIZE_WIDTH-1:0]  head_size_c;

   // S0 hash / increment
   logic [HASH_PAD_W-1:0]      hash_pad_c;
   logic [INDEX_WIDTH-1:0]     s0_idx_c;
   logic [COUNTER_WIDTH-1:0]   s0_inc_c;

   // Pipeline stages
   logic                       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic [INDEX_WIDTH-1:0]     s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
   logic [COUNTER_WIDTH-1:0]   s1_inc_q, s1_inc_d, s2_inc_q, s2_inc_d;

   // Last write, for read-first forwarding
   logic                       last_wr_vld_q, last_wr_vld_d;
   logic [INDEX_WIDTH-1:0]     last_wr_idx_q, last_wr_idx_d;
   logic [COUNTER_WIDTH-1:0]   last_wr_data_q, last_wr_data_d;
   logic [COUNTER_WIDTH-1:0]   old_c, new_c;
   logic [COUNTER_WIDTH:0]     sum_c;

   // Control
   sketch_state_e              state_q, state_d;
   logic [INDEX_WIDTH-1:0]     sweep_addr_q, sweep_addr_d;
   logic                       clear_pending_q, clear_pending_d;
   logic                       rd_pending_q, rd_pending_d;
   logic [INDEX_WIDTH-1:0]     rd_addr_q, rd_addr_d;
   logic                       rd_issue_q, rd_issue_d;
   logic                       sw_rd_ack_q, sw_rd_ack_d;
   logic [COUNTER_WIDTH-1:0]   sw_rd_data_q, sw_rd_data_d;
   logic                       clear_busy_q, clear_busy_d;
   logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
   logic                       pipe_empty_c, clr_accept_c, rd_accept_c, rd_fire_c;

   // RAM port drive
   logic                       ram_wr_en_c, ram_rd_en_c;
   logic [INDEX_WIDTH-1:0]     ram_wr_addr_c, ram_rd_addr_c;
   logic [COUNTER_WIDTH-1:0]   ram_wr_data_c, ram_rdata;

   // Only the key field of the flow entry is consumed.
   logic unused_flow_bits;
   assign unused_flow_bits = ^flow_entry;

   // Queue head and push data.
   assign push_data_c = {flow_entry[KEY_POS +: KEY_WIDTH], pkt_size};
   assign head_c      = fifo_mem_q[fifo_rd_ptr_q];
   assign head_key_c  = head_c[FIFO_W-1 -: KEY_WIDTH];
   assign head_size_c = head_c[PKT_SIZE_WIDTH-1:0];

   // XOR-fold of the seeded key into INDEX_WIDTH bits.
   always_comb begin
      hash_pad_c = HASH_PAD_W'(head_key_c ^ HASH_SEED);
      s0_idx_c   = '0;
      for (int unsigned i = 0; i < NUM_SLICES; i++) begin
         s0_idx_c = s0_idx_c ^ hash_pad_c[i*INDEX_WIDTH +: INDEX_WIDTH];
      end
      s0_inc_c = (COUNT_BYTES != 0) ? COUNTER_WIDTH'(head_size_c) : COUNTER_WIDTH'(1);
   end

   // S2 saturating add; forward the previous edge's write past the read-first RAM.
   always_comb begin
      old_c = (last_wr_vld_q && (last_wr_idx_q == s2_idx_q)) ? last_wr_data_q : ram_rdata;
      sum_c = {1'b0, old_c} + {1'b0, s2_inc_q};
      new_c = sum_c[COUNTER_WIDTH] ? '1 : sum_c[COUNTER_WIDTH-1:0];
   end

   // Request acceptance and pop gating; a same-cycle request already stops the pop.
   always_comb begin
      fifo_full_c  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
      fifo_empty_c = (fifo_cnt_q == '0);
      pipe_empty_c = !s1_vld_q && !s2_vld_q;
      clr_accept_c = sw_clear_req && (state_q == ST_RUN) && !clear_pending_q;
      rd_accept_c  = sw_rd_req && (state_q == ST_RUN) && !rd_pending_q && !rd_issue_q;
      rd_fire_c    = rd_pending_q && pipe_empty_c;
      push_c       = flow_entry_vld && !fifo_full_c;
      pop_c        = (state_q == ST_RUN) && !fifo_empty_c && !clear_pending_q &&
                     !rd_pending_q && !clr_accept_c && !rd_accept_c;
   end

   // Next-state, pipeline advance and RAM port selection.
   always_comb begin
      state_d         = state_q;
      sweep_addr_d    = sweep_addr_q;
      clear_pending_d = clear_pending_q;
      rd_pending_d    = rd_pending_q;
      rd_addr_d       = rd_addr_q;
      rd_issue_d      = 1'b0;
      sw_rd_ack_d     = 1'b0;
      sw_rd_data_d    = sw_rd_data_q;
      drop_count_d    = drop_count_q;
      s1_vld_d        = 1'b0;
      s1_idx_d        = s1_idx_q;
      s1_inc_d        = s1_inc_q;
      s2_vld_d        = s1_vld_q;
      s2_idx_d        = s1_idx_q;
      s2_inc_d        = s1_inc_q;
      last_wr_vld_d   = s2_vld_q;
      last_wr_idx_d   = s2_idx_q;
      last_wr_data_d  = new_c;
      fifo_wr_ptr_d   = fifo_wr_ptr_q;
      fifo_rd_ptr_d   = fifo_rd_ptr_q;
      fifo_cnt_d      = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ram_wr_en_c     = s2_vld_q;
      ram_wr_addr_c   = s2_idx_q;
      ram_wr_data_c   = new_c;
      ram_rd_en_c     = s1_vld_q || rd_fire_c;
      ram_rd_addr_c   = rd_fire_c ? rd_addr_q : s1_idx_q;

      if (push_c) fifo_wr_ptr_d = fifo_wr_ptr_q + FIFO_DEPTH_BITS'(1);
      if (flow_entry_vld && fifo_full_c) drop_count_d = sat_inc_drop(drop_count_q);

      if (pop_c) begin
         fifo_rd_ptr_d = fifo_rd_ptr_q + FIFO_DEPTH_BITS'(1);
         s1_vld_d      = 1'b1;
         s1_idx_d      = s0_idx_c;
         s1_inc_d      = s0_inc_c;
      end

      if (rd_issue_q) begin
         sw_rd_ack_d  = 1'b1;
         sw_rd_data_d = ram_rdata;
      end

      case (state_q)
         ST_CLEAR: begin
            ram_wr_en_c   = 1'b1;
            ram_wr_addr_c = sweep_addr_q;
            ram_wr_data_c = '0;
            sweep_addr_d  = sweep_addr_q + INDEX_WIDTH'(1);
            if (sweep_addr_q == LAST_ADDR) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (clr_accept_c) clear_pending_d = 1'b1;
            if (rd_accept_c) begin
               rd_pending_d = 1'b1;
               rd_addr_d    = sw_rd_addr;
            end
            if (rd_fire_c) begin
               rd_pending_d = 1'b0;
               rd_issue_d   = 1'b1;
            end
            // A pending read (including its ack cycle) goes ahead of the clear.
            if (clear_pending_q && pipe_empty_c && !rd_pending_q && !rd_issue_q) begin
               state_d         = ST_CLEAR;
               sweep_addr_d    = '0;
               clear_pending_d = 1'b0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase

      clear_busy_d = (state_d == ST_CLEAR) || clear_pending_d;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_CLEAR;
         sweep_addr_q    <= '0;
         clear_pending_q <= 1'b0;
         rd_pending_q    <= 1'b0;
         rd_addr_q       <= '0;
         rd_issue_q      <= 1'b0;
         sw_rd_ack_q     <= 1'b0;
         sw_rd_data_q    <= '0;
         clear_busy_q    <= 1'b1;
         drop_count_q    <= '0;
         s1_vld_q        <= 1'b0;
         s1_idx_q        <= '0;
         s1_inc_q        <= '0;
         s2_vld_q        <= 1'b0;
         s2_idx_q        <= '0;
         s2_inc_q        <= '0;
         last_wr_vld_q   <= 1'b0;
         last_wr_idx_q   <= '0;
         last_wr_data_q  <= '0;
         fifo_wr_ptr_q   <= '0;
         fifo_rd_ptr_q   <= '0;
         fifo_cnt_q      <= '0;
      end else begin
         state_q         <= state_d;
         sweep_addr_q    <= sweep_addr_d;
         clear_pending_q <= clear_pending_d;
         rd_pending_q    <= rd_pending_d;
         rd_addr_q       <= rd_addr_d;
         rd_issue_q      <= rd_issue_d;
         sw_rd_ack_q     <= sw_rd_ack_d;
         sw_rd_data_q    <= sw_rd_data_d;
         clear_busy_q    <= clear_busy_d;
         drop_count_q    <= drop_count_d;
         s1_vld_q        <= s1_vld_d;
         s1_idx_q        <= s1_idx_d;
         s1_inc_q        <= s1_inc_d;
         s2_vld_q        <= s2_vld_d;
         s2_idx_q        <= s2_idx_d;
         s2_inc_q        <= s2_inc_d;
         last_wr_vld_q   <= last_wr_vld_d;
         last_wr_idx_q   <= last_wr_idx_d;
         last_wr_data_q  <= last_wr_data_d;
         fifo_wr_ptr_q   <= fifo_wr_ptr_d;
         fifo_rd_ptr_q   <= fifo_rd_ptr_d;
         fifo_cnt_q      <= fifo_cnt_d;
      end
   end

   // Queue storage (no reset needed; pointers define occupancy).
   always_ff @(posedge clk) begin
      if (push_c) fifo_mem_q[fifo_wr_ptr_q] <= push_data_c;
   end

   sketch_counter_ram #(
      .ADDR_WIDTH (INDEX_WIDTH),
      .DATA_WIDTH (COUNTER_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en_c),
      .wr_addr (ram_wr_addr_c),
      .wr_data (ram_wr_data_c),
      .rd_en   (ram_rd_en_c),
      .rd_addr (ram_rd_addr_c),
      .rd_data (ram_rdata)
   );

   assign sw_rd_ack  = sw_rd_ack_q;
   assign sw_rd_data = sw_rd_data_q;
   assign clear_busy = clear_busy_q;
   assign drop_count = drop_count_q;

endmodule
